// File: rtl/bitwise_result_queue.sv
// bitwise_result_queue: first-word fall-through FIFO that buffers
// AND/OR/XOR result triples from the 16-bit bitwise unit and hands
// them to a consumer over a valid/ready interface.
// Optional feature macro: BRQ_ALMOST_FULL_EN adds a registered almost_full
// output that is raised when the occupancy after the current edge is at
// least AF_LEVEL.

package brq_pkg;
  // Ceiling log2 for sizing the pointers from DEPTH.
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction
endpackage

module bitwise_result_queue #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int AW       = brq_pkg::clogb2(DEPTH),
  parameter int AF_LEVEL = DEPTH - 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_and,
  input  logic [WIDTH-1:0] in_or,
  input  logic [WIDTH-1:0] in_xor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_and,
  output logic [WIDTH-1:0] out_or,
  output logic [WIDTH-1:0] out_xor,
  output logic [AW:0]      count
`ifdef BRQ_ALMOST_FULL_EN
  ,
  output logic             almost_full
`endif
);

  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  // One entry holds the whole triple so the three fields can never skew.
  logic [3*WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [AW:0]   count_next;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  // Queue state is fully described by the occupancy counter.
  assign full      = (count_reg == DEPTH_CNT);
  assign empty     = (count_reg == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign count     = count_reg;

  // A full queue refuses a push even if the head is popped in the same
  // cycle; an empty queue never bypasses the incoming triple.
  assign push = in_valid && !full;
  assign pop  = out_ready && !empty;

  // Fall-through read: the head is always presented combinationally.
  assign {out_and, out_or, out_xor} = mem[rd_ptr_reg];

  // Occupancy after this edge, ignoring flush (flush overrides in the register).
  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + 1'b1;
    end else if (pop && !push) begin
      count_next = count_reg - 1'b1;
    end
  end

  // Storage write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr_reg] <= {in_and, in_or, in_xor};
    end
  end

  // Pointer and occupancy update; flush discards any handshake in its cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_next;
    end
  end

`ifdef BRQ_ALMOST_FULL_EN
  localparam logic [AW:0] AF_CNT = (AW + 1)'(AF_LEVEL);
  logic almost_full_reg;

  assign almost_full = almost_full_reg;

  // Early throttle flag tracks the occupancy being loaded on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      almost_full_reg <= 1'b0;
    end else if (flush) begin
      almost_full_reg <= 1'b0;
    end else begin
      almost_full_reg <= (count_next >= AF_CNT);
    end
  end
`endif

endmodule
